// File: rtl/dcc_tap_scheduler.sv
// Dilated causal convolution tap scheduler.
// Per accepted sample: write it into the circular activation cache, issue K
// dilated tap reads (one every cycle), drive the shared MAC one cycle behind
// each read, then rescale the 2W-bit accumulator to W-bit Q(I).(W-I) with
// saturation and hold it on a valid/ready output.
// Optional build macro DCC_ROUND_EN: round-half-up before the rescale shift
// (default build truncates).
module dcc_tap_scheduler #(
  parameter int W      = 16,
  parameter int I      = 4,
  parameter int K      = 4,
  parameter int D      = 2,
  parameter int ADDR_W = 4,
  localparam int TAP_W = (K > 1) ? $clog2(K) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [W-1:0]            in_data,
  output logic                    cache_wr_en,
  output logic [ADDR_W-1:0]       cache_wr_addr,
  output logic [W-1:0]            cache_wr_data,
  output logic                    cache_rd_en,
  output logic [ADDR_W-1:0]       cache_rd_addr,
  output logic                    mac_en,
  output logic                    mac_clr,
  output logic                    mac_zero,
  output logic [TAP_W-1:0]        mac_tap,
  input  logic signed [2*W-1:0]   mac_acc,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [W-1:0]            out_data,
  output logic                    out_sat,
  output logic                    busy
);

  localparam int FILL_MAX = (K - 1) * D;
  localparam int FILL_W   = (FILL_MAX > 0) ? $clog2(FILL_MAX + 1) : 1;
  localparam int SHIFT    = W - I;

  // Saturation bounds of the W-bit output, sign-extended to 2W bits
  localparam logic signed [2*W-1:0] SAT_MAX = {{(W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [2*W-1:0] SAT_MIN = {{(W+1){1'b1}}, {(W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_CAPTURE,
    S_OUT
  } state_t;

  state_t              state, state_nxt;
  logic [TAP_W-1:0]    tap_cnt;
  logic [ADDR_W-1:0]   wr_ptr;
  logic [FILL_W-1:0]   fill;
  logic                accept;
  logic [31:0]         tap_off;

  logic                mac_en_p1;
  logic                mac_clr_p1;
  logic                mac_zero_p1;
  logic [TAP_W-1:0]    mac_tap_p1;

  logic signed [W-1:0] res_data_p2;
  logic                res_sat_p2;

  // Rescale accumulator to Q(I).(W-I); returns {saturated, data}
  function automatic logic [W:0] scale_sat(input logic signed [2*W-1:0] acc);
    logic signed [2*W-1:0] biased;
    logic signed [2*W-1:0] s;
`ifdef DCC_ROUND_EN
    biased = acc + signed'((2*W)'(64'd1 << (SHIFT - 1)));
`else
    biased = acc;
`endif
    s = biased >>> SHIFT;
    if (s > SAT_MAX)      return {1'b1, SAT_MAX[W-1:0]};
    else if (s < SAT_MIN) return {1'b1, SAT_MIN[W-1:0]};
    else                  return {1'b0, s[W-1:0]};
  endfunction

  // Tap offset behind the newest sample, in cache entries
  assign tap_off = 32'(tap_cnt) * 32'(D);

  // Next-state logic and the combinational stream/cache outputs
  always_comb begin
    state_nxt     = state;
    accept        = 1'b0;
    case (state)
      S_IDLE: begin
        if (in_valid && rst) begin
          accept    = 1'b1;
          state_nxt = S_READ;
        end
      end
      S_READ: begin
        if (tap_cnt == TAP_W'(K - 1)) state_nxt = S_DRAIN;
      end
      S_DRAIN:   state_nxt = S_CAPTURE;
      S_CAPTURE: state_nxt = S_OUT;
      S_OUT: begin
        if (out_ready) state_nxt = S_IDLE;
      end
      default:   state_nxt = S_IDLE;
    endcase

    in_ready      = (state == S_IDLE);
    cache_wr_en   = accept;
    cache_wr_addr = accept ? wr_ptr : '0;
    cache_wr_data = accept ? in_data : '0;
    cache_rd_en   = (state == S_READ);
    cache_rd_addr = (state == S_READ) ? (wr_ptr - tap_off[ADDR_W-1:0]) : '0;
    out_valid     = (state == S_OUT);
    busy          = (state != S_IDLE);
  end

  // State register, tap counter, write pointer and warm-up fill level
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      tap_cnt <= '0;
      wr_ptr  <= '0;
      fill    <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_READ) tap_cnt <= tap_cnt + TAP_W'(1);
      else                 tap_cnt <= '0;
      if (state == S_OUT && out_ready) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
        if (fill != FILL_W'(FILL_MAX)) fill <= fill + FILL_W'(1);
      end
    end
  end

  // p1: MAC controls trail each cache read by one cycle (RAM read latency)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mac_en_p1   <= 1'b0;
      mac_clr_p1  <= 1'b0;
      mac_zero_p1 <= 1'b0;
      mac_tap_p1  <= '0;
    end else begin
      mac_en_p1   <= (state == S_READ);
      mac_clr_p1  <= (state == S_READ) && (tap_cnt == '0);
      mac_zero_p1 <= (state == S_READ) && (tap_off > 32'(fill));
      mac_tap_p1  <= (state == S_READ) ? tap_cnt : '0;
    end
  end

  // p2: rescaled result captured once the accumulator has settled
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_data_p2 <= '0;
      res_sat_p2  <= 1'b0;
    end else if (state == S_CAPTURE) begin
      {res_sat_p2, res_data_p2} <= scale_sat(mac_acc);
    end
  end

  assign mac_en   = mac_en_p1;
  assign mac_clr  = mac_clr_p1;
  assign mac_zero = mac_zero_p1;
  assign mac_tap  = mac_tap_p1;
  assign out_data = res_data_p2;
  assign out_sat  = res_sat_p2;

endmodule

// File: tb/tb_dcc_tap_scheduler.sv
// Self-checking bench for dcc_tap_scheduler: directed table, randomized
// transactions against a transaction-level model, and a mid-read reset.
module tb_dcc_tap_scheduler;

  localparam int W = 16, I = 4, K = 4, D = 2, ADDR_W = 4, TAP_W = 2;
  localparam int SHIFT = W - I;
`ifdef DCC_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [W-1:0]      in_data;
  logic              cache_wr_en;
  logic [ADDR_W-1:0] cache_wr_addr;
  logic [W-1:0]      cache_wr_data;
  logic              cache_rd_en;
  logic [ADDR_W-1:0] cache_rd_addr;
  logic              mac_en;
  logic              mac_clr;
  logic              mac_zero;
  logic [TAP_W-1:0]  mac_tap;
  logic [2*W-1:0]    mac_acc;
  logic              out_valid;
  logic              out_ready;
  logic [W-1:0]      out_data;
  logic              out_sat;
  logic              busy;

  dcc_tap_scheduler #(.W(W), .I(I), .K(K), .D(D), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .cache_wr_en(cache_wr_en), .cache_wr_addr(cache_wr_addr), .cache_wr_data(cache_wr_data),
    .cache_rd_en(cache_rd_en), .cache_rd_addr(cache_rd_addr),
    .mac_en(mac_en), .mac_clr(mac_clr), .mac_zero(mac_zero), .mac_tap(mac_tap),
    .mac_acc(mac_acc),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int m_done = 0;   // samples completed since the last reset

  typedef struct {
    logic [W-1:0]   data;
    logic [2*W-1:0] acc;
    int             hold;
    logic [W-1:0]   exp_d;
    logic           exp_s;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  // Control snapshot; address/tap fields only meaningful under their strobes
  function automatic logic [63:0] mk(input bit ir, input bit we, input logic [3:0] wa,
                                     input bit re, input logic [3:0] ra, input bit me,
                                     input bit mc, input bit mz, input logic [1:0] mt,
                                     input bit ov, input bit bs);
    return 64'({ir, we, we ? wa : 4'h0, re, re ? ra : 4'h0, me, mc, mz,
                me ? mt : 2'b00, ov, bs});
  endfunction

  function automatic logic [63:0] act_ctl();
    return mk(in_ready, cache_wr_en, cache_wr_addr, cache_rd_en, cache_rd_addr,
              mac_en, mac_clr, mac_zero, mac_tap, out_valid, busy);
  endfunction

  function automatic logic [63:0] all_out();
    return 64'({in_ready, cache_wr_en, cache_wr_addr, cache_wr_data, cache_rd_en,
                cache_rd_addr, mac_en, mac_clr, mac_zero, mac_tap, out_valid,
                out_data, out_sat, busy});
  endfunction

  // Reference rescale: floor division by 2^(W-I), then clamp to W-bit range
  function automatic logic [W:0] ref_out(input logic [2*W-1:0] acc);
    logic [2*W-1:0] sum;
    longint v, q, div, hi, lo;
    div = longint'(1) << SHIFT;
    hi  = (longint'(1) << (W - 1)) - 1;
    lo  = -(longint'(1) << (W - 1));
    sum = RND ? acc + (2*W)'(1 << (SHIFT - 1)) : acc;
    v   = longint'($signed(sum));
    q   = v / div;
    if (v < 0 && (v % div) != 0) q = q - 1;
    if (q > hi) return {1'b1, W'(hi)};
    if (q < lo) return {1'b1, W'(lo)};
    return {1'b0, W'(q)};
  endfunction

  // One sample from acceptance to handshake; entered and left at an IDLE negedge
  task automatic run_txn(input logic [W-1:0] d, input logic [2*W-1:0] acc, input int hold,
                         input logic [W-1:0] exp_d, input logic exp_s, input string tag);
    int ptr, n, tap;
    logic [3:0] ra;
    ptr = m_done % 16;
    in_valid = 1'b1; in_data = d; mac_acc = acc; out_ready = 1'($urandom);
    #1;
    n = 0;
    while (!in_ready && n < 64) begin
      @(negedge clk); #1; n++;
    end
    if (!in_ready) begin
      $display("FAIL accept_timeout %s got in_ready=0 want 1", tag);
      $fatal(1, "accept timeout");
    end
    chk($sformatf("ctl c0 %s", tag), act_ctl(),
        mk(1, 1, 4'(ptr), 0, 0, 0, 0, 0, 0, 0, 0));
    chk($sformatf("wr_data %s", tag), 64'(cache_wr_data), 64'(d));
    for (int c = 1; c <= K + 2; c++) begin
      @(negedge clk);
      in_data = W'($urandom); out_ready = 1'($urandom);
      #1;
      tap = c - 2;
      ra  = 4'((((ptr - (c - 1) * D) % 16) + 16) % 16);
      chk($sformatf("ctl c%0d %s", c, tag), act_ctl(),
          mk(0, 0, 0, (c <= K), ra, (c >= 2 && c <= K + 1), (tap == 0),
             (c >= 2 && c <= K + 1 && tap * D > m_done), 2'(tap), 0, 1));
    end
    for (int h = 0; h <= hold; h++) begin
      @(negedge clk);
      in_data = W'($urandom);
      out_ready = (h == hold);
      #1;
      chk($sformatf("ctl out%0d %s", h, tag), act_ctl(),
          mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
      chk($sformatf("out_data %s", tag), 64'(out_data), 64'(exp_d));
      chk($sformatf("out_sat %s", tag), 64'(out_sat), 64'(exp_s));
    end
    @(negedge clk);
    m_done++;
    in_valid = 1'b0;
    #1;
    chk($sformatf("ctl idle %s", tag), act_ctl(), mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic run_rand(input int n, input string tag);
    logic [2*W-1:0] acc;
    logic [W:0]     r;
    for (int i = 0; i < n; i++) begin
      acc = 32'($signed($urandom) >>> $urandom_range(0, 12));
      r   = ref_out(acc);
      run_txn(W'($urandom), acc, $urandom_range(0, 3), r[W-1:0], r[W],
              $sformatf("%s%0d", tag, i));
    end
  endtask

  initial begin
    tbl[0] = '{16'h1000, 32'h0100_0000, 0, 16'h1000, 1'b0};
    tbl[1] = '{16'h0123, 32'h7FFF_0000, 0, 16'h7FFF, 1'b1};
    tbl[2] = '{16'hFEDC, 32'h8000_0000, 2, 16'h8000, 1'b1};
    tbl[3] = '{16'h0FFF, 32'h00FF_F000, 0, 16'h0FFF, 1'b0};
    tbl[4] = '{16'h0001, 32'h0000_0800, 0, RND ? 16'h0001 : 16'h0000, 1'b0};
    tbl[5] = '{16'h5555, 32'hFFFF_F000, 5, 16'hFFFF, 1'b0};
    tbl[6] = '{16'hAAAA, 32'hF7FF_F000, 0, 16'h8000, 1'b1};
    tbl[7] = '{16'h7FFF, 32'hF800_0000, 1, 16'h8000, 1'b0};
    tbl[8] = '{16'h8000, 32'h07FF_F800, 0, 16'h7FFF, RND};

    rst = 1'b0; in_valid = 1'b0; in_data = '0; mac_acc = '0; out_ready = 1'b0;
    #1;
    chk("reset_outputs", all_out(), 64'h0004_0000_0000_0000);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("post_reset_outputs", all_out(), 64'h0004_0000_0000_0000);

    for (int i = 0; i < 9; i++)
      run_txn(tbl[i].data, tbl[i].acc, tbl[i].hold, tbl[i].exp_d, tbl[i].exp_s,
              $sformatf("tbl%0d", i));

    run_rand(30, "rnd");

    // Reset while reading tap 2; the abort must be immediate and restart at addr 0
    in_valid = 1'b1; in_data = 16'h2222; mac_acc = 32'h0;
    #1;
    chk("abort_accept", 64'(cache_wr_en), 64'd1);
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("abort_outputs", all_out(), 64'h0004_0000_0000_0000);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    m_done = 0;
    #1;
    chk("abort_idle", act_ctl(), mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    run_txn(16'h1000, 32'h0100_0000, 0, 16'h1000, 1'b0, "after_abort");
    run_rand(4, "post");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
